// File: rtl/rv32_mod_issue_scoreboard_if.sv
// Issue/writeback/status bundle between the rv32imc decoder side and the hazard scoreboard.
// master = decoder/pipeline control, slave = scoreboard.
interface rv32_mod_issue_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int TOTAL_W  = 6
);
    logic                issue_valid;
    logic                issue_ready;
    logic [4:0]          issue_rs1;
    logic [4:0]          issue_rs2;
    logic [4:0]          issue_rd;
    logic                issue_writes_rd;
    logic                wb_valid;
    logic [4:0]          wb_rd;
    logic                flush;
    logic [NUM_REGS-1:0] busy_mask;
    logic [TOTAL_W-1:0]  outstanding;
    logic                idle;
    logic                wb_underflow;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_writes_rd,
        output wb_valid, wb_rd, flush,
        input  issue_ready, busy_mask, outstanding, idle, wb_underflow
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_writes_rd,
        input  wb_valid, wb_rd, flush,
        output issue_ready, busy_mask, outstanding, idle, wb_underflow
    );
endinterface

// File: rtl/rv32_mod_issue_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters gate in-order issue.
// Optional macro RV32_SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear the hazard.
module rv32_mod_issue_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int TOTAL_W  = 6
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    rv32_mod_issue_scoreboard_if.slave     sb_if
);
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TOTAL_W-1:0] TOT_MAX = {TOTAL_W{1'b1}};

    logic [CNT_W-1:0]    r_cnt [NUM_REGS];
    logic [TOTAL_W-1:0]  r_total;
    logic                r_underflow;

    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic                w_rs1_haz;
    logic                w_rs2_haz;
    logic                w_rd_full;
    logic                w_ready;
    logic                w_accept;
    logic                w_uf;

    always_comb begin
        w_rs1_haz = w_busy[sb_if.issue_rs1];
        w_rs2_haz = w_busy[sb_if.issue_rs2];
        w_rd_full = sb_if.issue_writes_rd && (sb_if.issue_rd != 5'd0) &&
                    (r_cnt[sb_if.issue_rd] == CNT_MAX);
`ifdef RV32_SCOREBOARD_WB_BYPASS_EN
        // Last pending write retiring now: datapath forwards the wb value.
        if (sb_if.wb_valid && (sb_if.wb_rd == sb_if.issue_rs1) &&
            (r_cnt[sb_if.issue_rs1] == CNT_W'(1)))
            w_rs1_haz = 1'b0;
        if (sb_if.wb_valid && (sb_if.wb_rd == sb_if.issue_rs2) &&
            (r_cnt[sb_if.issue_rs2] == CNT_W'(1)))
            w_rs2_haz = 1'b0;
        if (sb_if.wb_valid && (sb_if.wb_rd == sb_if.issue_rd))
            w_rd_full = 1'b0;
`endif
    end

    assign w_ready  = !sb_if.flush && !w_rs1_haz && !w_rs2_haz && !w_rd_full &&
                      (r_total != TOT_MAX);
    assign w_accept = sb_if.issue_valid && w_ready;
    assign w_uf     = sb_if.wb_valid && (sb_if.wb_rd != 5'd0) &&
                      (r_cnt[sb_if.wb_rd] == '0) && !sb_if.flush;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // x0 is never tracked, so its increment is tied off and its count stays zero.
            assign w_inc[gi]  = w_accept && sb_if.issue_writes_rd &&
                                (sb_if.issue_rd == 5'(gi)) && (gi != 0);
            assign w_dec[gi]  = sb_if.wb_valid && (sb_if.wb_rd == 5'(gi)) &&
                                (r_cnt[gi] != '0);
            assign w_busy[gi] = (r_cnt[gi] != '0);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    r_cnt[gi] <= '0;
                else if (sb_if.flush)
                    r_cnt[gi] <= '0;
                else if (w_inc[gi] && !w_dec[gi])
                    r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                else if (w_dec[gi] && !w_inc[gi])
                    r_cnt[gi] <= r_cnt[gi] - CNT_W'(1);
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_total     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (sb_if.flush)
                r_total <= '0;
            else
                r_total <= r_total + TOTAL_W'(|w_inc) - TOTAL_W'(|w_dec);
            if (w_uf)
                r_underflow <= 1'b1;
        end
    end

    assign sb_if.issue_ready  = w_ready;
    assign sb_if.busy_mask    = w_busy;
    assign sb_if.outstanding  = r_total;
    assign sb_if.idle         = (r_total == '0);
    assign sb_if.wb_underflow = r_underflow;
endmodule

// File: tb/tb_rv32_mod_issue_scoreboard.sv
// Directed bench for the issue scoreboard; expectations hand-computed per scenario.
module tb_rv32_mod_issue_scoreboard;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    rv32_mod_issue_scoreboard_if #(.NUM_REGS(32), .TOTAL_W(6)) u_if ();

    rv32_mod_issue_scoreboard #(.NUM_REGS(32), .CNT_W(2), .TOTAL_W(6)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .sb_if   (u_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.issue_valid     = 1'b0;
        u_if.issue_rs1       = 5'd0;
        u_if.issue_rs2       = 5'd0;
        u_if.issue_rd        = 5'd0;
        u_if.issue_writes_rd = 1'b0;
        u_if.wb_valid        = 1'b0;
        u_if.wb_rd           = 5'd0;
        u_if.flush           = 1'b0;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        u_if.issue_valid     = 1'b1;
        u_if.issue_rs1       = 5'd0;
        u_if.issue_rs2       = 5'd0;
        u_if.issue_rd        = rd;
        u_if.issue_writes_rd = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_inputs();

        // Reset state
        #3;
        check_eq("rst_busy",      u_if.busy_mask,    32'd0);
        check_eq("rst_outstand",  u_if.outstanding,  32'd0);
        check_eq("rst_idle",      u_if.idle,         32'd1);
        check_eq("rst_underflow", u_if.wb_underflow, 32'd0);
        check_eq("rst_ready",     u_if.issue_ready,  32'd1);
        #9 rst_n = 1'b1;
        step();

        // RAW on x5
        issue_wr(5'd5);
        #1 check_eq("x5_issue_ready", u_if.issue_ready, 32'd1);
        step();
        idle_inputs();
        #1;
        check_eq("x5_busy",     u_if.busy_mask,   32'h0000_0020);
        check_eq("x5_outstand", u_if.outstanding, 32'd1);
        check_eq("x5_idle",     u_if.idle,        32'd0);
        u_if.issue_valid = 1'b1;
        u_if.issue_rs1   = 5'd5;
        #1 check_eq("raw_x5_stall", u_if.issue_ready, 32'd0);
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 5'd5;
`ifdef RV32_SCOREBOARD_WB_BYPASS_EN
        #1 check_eq("raw_x5_wb_cycle", u_if.issue_ready, 32'd1);
`else
        #1 check_eq("raw_x5_wb_cycle", u_if.issue_ready, 32'd0);
`endif
        step();
        u_if.wb_valid = 1'b0;
        #1;
        check_eq("raw_x5_after_wb", u_if.issue_ready, 32'd1);
        check_eq("x5_clear_busy",   u_if.busy_mask,   32'd0);
        check_eq("x5_clear_out",    u_if.outstanding, 32'd0);
        step();
        idle_inputs();

        // x0 is never tracked
        for (int i = 0; i < 3; i++) begin
            issue_wr(5'd0);
            #1 check_eq($sformatf("x0_ready_%0d", i), u_if.issue_ready, 32'd1);
            step();
        end
        idle_inputs();
        #1;
        check_eq("x0_busy",    u_if.busy_mask,   32'd0);
        check_eq("x0_outstand", u_if.outstanding, 32'd0);

        // WAW saturation on x7
        for (int i = 0; i < 3; i++) begin
            issue_wr(5'd7);
            #1 check_eq($sformatf("x7_waw_ready_%0d", i), u_if.issue_ready, 32'd1);
            step();
        end
        idle_inputs();
        #1 check_eq("x7_outstand3", u_if.outstanding, 32'd3);
        u_if.issue_valid = 1'b1;
        u_if.issue_rs2   = 5'd7;
        #1 check_eq("x7_rs2_stall", u_if.issue_ready, 32'd0);
        issue_wr(5'd7);
        #1 check_eq("x7_sat_stall", u_if.issue_ready, 32'd0);
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 5'd7;
`ifdef RV32_SCOREBOARD_WB_BYPASS_EN
        #1 check_eq("x7_sat_wb_ready", u_if.issue_ready, 32'd1);
        step();
        idle_inputs();
        #1 check_eq("x7_sat_wb_out", u_if.outstanding, 32'd3);
`else
        #1 check_eq("x7_sat_wb_ready", u_if.issue_ready, 32'd0);
        step();
        u_if.wb_valid = 1'b0;
        #1 check_eq("x7_after_wb_out", u_if.outstanding, 32'd2);
        check_eq("x7_after_wb_ready", u_if.issue_ready, 32'd1);
        step();
        idle_inputs();
        #1 check_eq("x7_reissue_out", u_if.outstanding, 32'd3);
`endif

        // Flush with pending x3/x9 (on top of x7), plus same-cycle issue and wb
        issue_wr(5'd3);
        step();
        issue_wr(5'd9);
        step();
        idle_inputs();
        #1 check_eq("pre_flush_out", u_if.outstanding, 32'd5);
        issue_wr(5'd10);
        u_if.flush    = 1'b1;
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 5'd3;
        #1 check_eq("flush_ready", u_if.issue_ready, 32'd0);
        step();
        idle_inputs();
        #1;
        check_eq("flush_out",       u_if.outstanding,  32'd0);
        check_eq("flush_idle",      u_if.idle,         32'd1);
        check_eq("flush_busy",      u_if.busy_mask,    32'd0);
        check_eq("flush_underflow", u_if.wb_underflow, 32'd0);

        // wb to x0 is ignored
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 5'd0;
        step();
        idle_inputs();
        #1 check_eq("wb_x0_no_uf", u_if.wb_underflow, 32'd0);

        // Underflow on x12, sticky through later traffic
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 5'd12;
        step();
        idle_inputs();
        #1 check_eq("uf_set", u_if.wb_underflow, 32'd1);
        issue_wr(5'd4);
        step();
        idle_inputs();
        u_if.wb_valid = 1'b1;
        u_if.wb_rd    = 5'd4;
        step();
        idle_inputs();
        #1;
        check_eq("uf_sticky",    u_if.wb_underflow, 32'd1);
        check_eq("uf_drain_out", u_if.outstanding,  32'd0);

        // Asynchronous reset mid-cycle
        issue_wr(5'd6);
        step();
        idle_inputs();
        #1 check_eq("pre_arst_busy", u_if.busy_mask, 32'h0000_0040);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_underflow", u_if.wb_underflow, 32'd0);
        check_eq("arst_busy",      u_if.busy_mask,    32'd0);
        check_eq("arst_outstand",  u_if.outstanding,  32'd0);
        #3 rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
